// File: rtl/sysid_check_master_pkg.sv
// Shared state encoding, bus addresses and data width for the system-ID check master.
package sysid_check_master_pkg;

    localparam int DATA_W = 32;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_ID  = 2'd1,
        ST_RD_TS  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only bus between the check master and the system-ID slave.
interface sysid_check_master_if;
    import sysid_check_master_pkg::*;

    logic              avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_check_master_avm_read_timeout.sv
// Stall counter for a single Avalon read: counts stalled cycles, flags the last allowed one.
module avm_read_timeout #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 9
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expired means this stalled cycle is the last one the read may spend waiting.
    assign expired = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sysid_check_master.sv
// Reads the system-ID slave (ID word, then timestamp) and reports whether both match build values.
module sysid_check_master
    import sysid_check_master_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd1768888067,
    parameter logic [31:0] EXPECTED_TS    = 32'd1227733144,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          TO_W           = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    sysid_check_master_if.master     avm,
    output logic                     busy,
    output logic                     done,
    output logic                     id_ok,
    output logic                     ts_ok,
    output logic                     timed_out,
    output logic [DATA_W-1:0]        id_value,
    output logic [DATA_W-1:0]        ts_value
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] id_value_q, id_value_d;
    logic [DATA_W-1:0] ts_value_q, ts_value_d;
    logic              timed_out_q, timed_out_d;
    logic              id_ok_q, id_ok_d;
    logic              ts_ok_q, ts_ok_d;

    logic rd;
    logic addr;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_expired;
    logic id_match;
    logic ts_match;

    avm_read_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    // A timed-out run never reports a match, whatever was captured.
    assign id_match = (id_value_q == EXPECTED_ID) && !timed_out_q;
    assign ts_match = (ts_value_q == EXPECTED_TS) && !timed_out_q;

    always_comb begin
        state_d     = state_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;
        timed_out_d = timed_out_q;
        id_ok_d     = id_ok_q;
        ts_ok_d     = ts_ok_q;
        rd          = 1'b0;
        addr        = ADDR_ID;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    id_value_d  = '0;
                    ts_value_d  = '0;
                    timed_out_d = 1'b0;
                    id_ok_d     = 1'b0;
                    ts_ok_d     = 1'b0;
                    cnt_clr     = 1'b1;
                    state_d     = ST_RD_ID;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                rd   = 1'b1;
                addr = (state_q == ST_RD_TS) ? ADDR_TS : ADDR_ID;
                // Completion is tested first so a slave answering on the last allowed cycle wins.
                if (!avm.avm_waitrequest) begin
                    cnt_clr = 1'b1;
                    if (state_q == ST_RD_ID) begin
                        id_value_d = avm.avm_readdata;
                        state_d    = ST_RD_TS;
                    end else begin
                        ts_value_d = avm.avm_readdata;
                        state_d    = ST_REPORT;
                    end
                end else if (cnt_expired) begin
                    timed_out_d = 1'b1;
                    state_d     = ST_REPORT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_REPORT: begin
                id_ok_d = id_match;
                ts_ok_d = ts_match;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            id_value_q  <= '0;
            ts_value_q  <= '0;
            timed_out_q <= 1'b0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
            timed_out_q <= timed_out_d;
            id_ok_q     <= id_ok_d;
            ts_ok_q     <= ts_ok_d;
        end
    end

    assign avm.avm_read    = rd;
    assign avm.avm_address = addr;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_REPORT);
    // The verdict is presented alongside done, then held by the flags registered at its end.
    assign id_ok     = (state_q == ST_REPORT) ? id_match : id_ok_q;
    assign ts_ok     = (state_q == ST_REPORT) ? ts_match : ts_ok_q;
    assign timed_out = timed_out_q;
    assign id_value  = id_value_q;
    assign ts_value  = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master with a small stalling system-ID slave model.
module tb_sysid_check_master;

    localparam logic [31:0] EXP_ID = 32'd1768888067;
    localparam logic [31:0] EXP_TS = 32'd1227733144;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, id_ok, ts_ok, timed_out;
    logic [31:0] id_value, ts_value;

    logic [31:0] slave_word0 = EXP_ID;
    logic [31:0] slave_word1 = EXP_TS;
    int          stall_n = 0;
    logic        stuck = 1'b0;
    int          rd_cycles = 0;

    int n_checks = 0;
    int n_fail   = 0;

    sysid_check_master_if avm ();

    sysid_check_master #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (8),
        .TO_W           (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .avm       (avm),
        .busy      (busy),
        .done      (done),
        .id_ok     (id_ok),
        .ts_ok     (ts_ok),
        .timed_out (timed_out),
        .id_value  (id_value),
        .ts_value  (ts_value)
    );

    always #5 clk = ~clk;

    // Slave: stalls each read for stall_n cycles, or forever while stuck.
    assign avm.avm_readdata    = avm.avm_address ? slave_word1 : slave_word0;
    assign avm.avm_waitrequest = stuck || (avm.avm_read && (rd_cycles < stall_n));

    always @(posedge clk) begin
        if (avm.avm_read && avm.avm_waitrequest) rd_cycles <= rd_cycles + 1;
        else                                     rd_cycles <= 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in cycle N+1; returns the cycle offset of done, or -1 if it never came.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    initial begin
        int lat;
        int nrd;
        int ndone;

        // Reset state
        step();
        step();
        check_eq("rst_read", avm.avm_read, 0);
        check_eq("rst_addr", avm.avm_address, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_flags", {id_ok, ts_ok, timed_out}, 0);
        check_eq("rst_id_value", id_value, 0);
        check_eq("rst_ts_value", ts_value, 0);
        reset_n = 1'b1;
        step();

        // 1: zero-wait run, defaults match
        pulse_start();
        check_eq("t1_n1_read", avm.avm_read, 1);
        check_eq("t1_n1_addr", avm.avm_address, 0);
        check_eq("t1_n1_busy", busy, 1);
        step();
        check_eq("t1_n2_read", avm.avm_read, 1);
        check_eq("t1_n2_addr", avm.avm_address, 1);
        check_eq("t1_n2_done", done, 0);
        step();
        check_eq("t1_n3_done", done, 1);
        check_eq("t1_n3_read", avm.avm_read, 0);
        check_eq("t1_id_ok", id_ok, 1);
        check_eq("t1_ts_ok", ts_ok, 1);
        check_eq("t1_timed_out", timed_out, 0);
        check_eq("t1_id_value", id_value, EXP_ID);
        check_eq("t1_ts_value", ts_value, EXP_TS);
        step();
        check_eq("t1_n4_done", done, 0);
        check_eq("t1_n4_busy", busy, 0);
        check_eq("t1_n4_id_ok_held", id_ok, 1);
        check_eq("t1_n4_ts_ok_held", ts_ok, 1);

        // 2: timestamp word reads back zero
        slave_word1 = 32'd0;
        pulse_start();
        wait_done(lat);
        check_eq("t2_latency", lat, 3);
        check_eq("t2_id_ok", id_ok, 1);
        check_eq("t2_ts_ok", ts_ok, 0);
        check_eq("t2_ts_value", ts_value, 0);
        step();
        check_eq("t2_ts_ok_held", ts_ok, 0);
        slave_word1 = EXP_TS;

        // 3: five stall cycles on each read
        stall_n = 5;
        pulse_start();
        for (int i = 1; i <= 12; i++) begin
            check_eq("t3_read_stable", avm.avm_read, 1);
            check_eq("t3_addr_stable", avm.avm_address, 32'(i > 6));
            step();
        end
        check_eq("t3_n13_done", done, 1);
        check_eq("t3_id_ok", id_ok, 1);
        check_eq("t3_ts_ok", ts_ok, 1);
        check_eq("t3_timed_out", timed_out, 0);
        stall_n = 0;
        step();

        // 4: slave stuck in waitrequest
        stuck = 1'b1;
        pulse_start();
        nrd = 0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (avm.avm_read === 1'b1) nrd++;
            step();
            lat++;
        end
        check_eq("t4_latency", lat, 9);
        check_eq("t4_read_cycles", nrd, 8);
        check_eq("t4_read_dropped", avm.avm_read, 0);
        check_eq("t4_timed_out", timed_out, 1);
        check_eq("t4_id_ok", id_ok, 0);
        check_eq("t4_ts_ok", ts_ok, 0);
        check_eq("t4_id_value", id_value, 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        check_eq("t4_extra_done", ndone, 0);
        check_eq("t4_timed_out_held", timed_out, 1);
        stuck = 1'b0;

        // 5: starts during RD_TS and REPORT are ignored; a later start clears the flags
        pulse_start();
        check_eq("t5_timed_out_cleared", timed_out, 0);
        step();
        check_eq("t5_in_rd_ts", avm.avm_address, 1);
        start = 1'b1;
        step();
        check_eq("t5_done", done, 1);
        check_eq("t5_id_ok", id_ok, 1);
        step();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        check_eq("t5_extra_done", ndone, 0);
        check_eq("t5_idle", busy, 0);
        slave_word0 = 32'hDEAD_BEEF;
        pulse_start();
        check_eq("t5_id_ok_cleared", id_ok, 0);
        check_eq("t5_ts_ok_cleared", ts_ok, 0);
        check_eq("t5_id_value_cleared", id_value, 0);
        check_eq("t5_ts_value_cleared", ts_value, 0);
        wait_done(lat);
        check_eq("t5_latency2", lat, 3);
        check_eq("t5_bad_id_ok", id_ok, 0);
        check_eq("t5_good_ts_ok", ts_ok, 1);
        check_eq("t5_bad_id_value", id_value, 32'hDEAD_BEEF);
        slave_word0 = EXP_ID;
        step();

        // 6: asynchronous reset during an ID-read stall
        stuck = 1'b1;
        pulse_start();
        step();
        step();
        check_eq("t6_stalled_read", avm.avm_read, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_read", avm.avm_read, 0);
        check_eq("t6_async_busy", busy, 0);
        check_eq("t6_async_done", done, 0);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        check_eq("t6_no_done", ndone, 0);
        stuck = 1'b0;
        reset_n = 1'b1;
        step();
        pulse_start();
        wait_done(lat);
        check_eq("t6_clean_latency", lat, 3);
        check_eq("t6_clean_id_ok", id_ok, 1);
        check_eq("t6_clean_ts_ok", ts_ok, 1);
        check_eq("t6_clean_timed_out", timed_out, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
